// File: rtl/darkfetch_pkg.sv
// darkfetch_pkg: shared types and constants for the darkfetch instruction-fetch block
package darkfetch_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } fetch_entry_t;
   localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
   localparam logic [31:0] FETCH_STRIDE = 32'd4;
endpackage

// File: rtl/darkfetch_fifo.sv
// darkfetch_fifo: prefetch FIFO of {pc, data} fetch entries
//   XCLK      in   clock
//   XRES      in   asynchronous active-low reset
//   push      in   write wr_entry at the tail
//   wr_entry  in   entry to write
//   pop       in   drop the head entry
//   flush     in   empty the FIFO (wins over push/pop)
//   count     out  number of valid entries (0..DEPTH)
//   head      out  entry at the head (meaningful only when count != 0)
module darkfetch_fifo
   import darkfetch_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
)(
   input  logic          XCLK,
   input  logic          XRES,
   input  logic          push,
   input  fetch_entry_t  wr_entry,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output fetch_entry_t  head
);
   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   always_ff @(posedge XCLK or negedge XRES)
      if (!XRES) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   // storage needs no reset: count gates every read of it
   always_ff @(posedge XCLK)
      if (push && !flush) mem[wr_ptr] <= wr_entry;
   assign head = mem[rd_ptr];
endmodule

// File: rtl/darkfetch.sv
// darkfetch: darkbus instruction-fetch initiator with prefetch FIFO and branch redirect
//   XCLK       in   clock
//   XRES       in   asynchronous active-low reset
//   BUS_ADDR   out  darkbus read address
//   BUS_EN     out  darkbus read enable
//   BUS_DATA   in   darkbus read data, one cycle after BUS_EN
//   BUS_VALID  in   darkbus read data valid
//   REDIR      in   redirect from execute
//   REDIR_PC   in   redirect target
//   IF_VALID   out  head entry available
//   IF_DATA    out  head instruction (NOP when empty)
//   IF_PC      out  head address (holds last value when empty)
//   IF_READY   in   decode accepts head
//   IF_FAULT   out  sticky misaligned-redirect flag, only with DARKFETCH_ALIGN_CHECK_EN
module darkfetch
   import darkfetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        XCLK,
   input  logic        XRES,
   output logic [31:0] BUS_ADDR,
   output logic        BUS_EN,
   input  logic [31:0] BUS_DATA,
   input  logic        BUS_VALID,
   input  logic        REDIR,
   input  logic [31:0] REDIR_PC,
   output logic        IF_VALID,
   output logic [31:0] IF_DATA,
   output logic [31:0] IF_PC,
   input  logic        IF_READY
`ifdef DARKFETCH_ALIGN_CHECK_EN
   ,output logic       IF_FAULT
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [31:0]   pc_q, pcin_q, pc_hold_q;
   logic          inflight_q, fault_q, issue, push, pop;
   logic [CW-1:0] count, credit;
   fetch_entry_t  head;
   // an in-flight read already owns a FIFO slot, so it counts against space
   assign credit   = count + CW'(inflight_q);
   assign issue    = XRES && !REDIR && (credit < CW'(DEPTH)) && !fault_q;
   assign push     = BUS_VALID && inflight_q && !REDIR;
   assign pop      = IF_VALID && IF_READY && !REDIR;
   assign BUS_EN   = issue;
   assign BUS_ADDR = pc_q;
   assign IF_VALID = count != '0;
   assign IF_DATA  = IF_VALID ? head.data : NOP_INSN;
   assign IF_PC    = IF_VALID ? head.pc : pc_hold_q;
   darkfetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .XCLK     (XCLK),
      .XRES     (XRES),
      .push     (push),
      .wr_entry ('{pc: pcin_q, data: BUS_DATA}),
      .pop      (pop),
      .flush    (REDIR),
      .count    (count),
      .head     (head)
   );
   always_ff @(posedge XCLK or negedge XRES)
      if (!XRES) begin
         pc_q       <= RESET_PC;
         pcin_q     <= RESET_PC;
         inflight_q <= 1'b0;
      end else if (REDIR) begin
         pc_q       <= REDIR_PC & ~32'd3;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            pc_q   <= pc_q + FETCH_STRIDE;
            pcin_q <= pc_q;
         end
      end
   // IF_PC keeps showing the last head address while the FIFO is empty
   always_ff @(posedge XCLK or negedge XRES)
      if (!XRES) pc_hold_q <= RESET_PC;
      else if (IF_VALID) pc_hold_q <= head.pc;
`ifdef DARKFETCH_ALIGN_CHECK_EN
   always_ff @(posedge XCLK or negedge XRES)
      if (!XRES) fault_q <= 1'b0;
      else if (REDIR) fault_q <= |REDIR_PC[1:0];
   assign IF_FAULT = fault_q;
`else
   assign fault_q = 1'b0;
`endif
endmodule

// File: doc/darkfetch.md
# darkfetch

Instruction-fetch initiator for the darkbus instruction port: drives the producer side of darkbus into the on-chip instruction ROM, tracks the one-cycle read latency, and buffers returned words with their PCs in a small prefetch FIFO. It sits between the instruction ROM and the core decode stage. It supports branch redirects with flush, and can sustain one instruction per cycle.

## Interface
- DEPTH, 4: prefetch FIFO entries; power of two, at least 2. A depth of at least 3 is required for full throughput.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- XCLK  in  1  clock; all state updates on the rising edge.
- XRES  in  1  reset, asynchronous, active-low.
- BUS  darkbus.prod  -  drives addr[31:0] and en; samples data[31:0] and valid, where the responder returns data and valid one cycle after en.
- REDIR  in  1  redirect request from execute (taken branch or jump).
- REDIR_PC  in  32  redirect target; sampled when REDIR=1.
- IF_VALID  out  1  head FIFO entry is available.
- IF_DATA  out  32  instruction word at the FIFO head.
- IF_PC  out  32  address of IF_DATA.
- IF_READY  in  1  decode accepts the head entry.
- IF_FAULT  out  1  sticky misaligned-redirect flag; present only with DARKFETCH_ALIGN_CHECK_EN.

## Operation
- State:
  - pc_q: next fetch address.
  - inflight_q: 1 when a read was issued in the previous cycle.
  - pcin_q: address of that in-flight read.
  - FIFO: DEPTH entries of {pc, data}, with rd_ptr, wr_ptr and count.
- Issue condition: issue = !REDIR && (count + inflight_q < DEPTH) && !fault_q.
  - BUS.en = issue and BUS.addr = pc_q, both combinational from registers and REDIR.
  - On issue: pc_q <= pc_q + 4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), inflight_q <= 1, pcin_q <= pc_q.
  - Without issue: inflight_q <= 0.
- Push: BUS.valid && inflight_q && !REDIR writes {pcin_q, BUS.data} at wr_ptr. Credit accounting guarantees space, so a push never overflows.
  - A BUS.valid with inflight_q=0 is ignored. This covers stale responses after reset or after a redirect.
- Pop: IF_VALID && IF_READY && !REDIR advances rd_ptr.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - Pointers wrap modulo DEPTH.
- Outputs: IF_VALID = (count != 0). IF_DATA and IF_PC come from the head entry.
  - When the FIFO is empty, IF_DATA = 32'h0000_0013 (NOP) and IF_PC holds its last value.
- Redirect cycle (REDIR=1):
  - No issue, no push, no pop.
  - The FIFO is flushed: count <= 0 and pointers <= 0.
  - inflight_q <= 0 and pc_q <= REDIR_PC with bits [1:0] forced to 0.
  - The response arriving in this cycle is dropped. No read was issued in this cycle, so nothing stale returns afterwards.
  - Back-to-back redirects: the last one wins, and no fetch happens until the first cycle with REDIR=0.
- Reset (asynchronous, any time):
  - pc_q=RESET_PC, inflight_q=0, count=0, pointers=0, fault_q=0.
  - Outputs: IF_VALID=0, BUS.en=0 (while XRES=0), IF_FAULT=0.
  - A read in flight when reset is asserted is discarded.

## Timing
- First issue occurs in the first cycle with XRES=1 (cycle 0).
  - BUS.valid returns in cycle 1 and is pushed at the end of cycle 1.
  - IF_VALID=1 in cycle 2.
- Redirect to first IF_VALID: 3 cycles. REDIR in cycle 0, issue in cycle 1, response in cycle 2, IF_VALID in cycle 3.
- Steady state with IF_READY=1 and DEPTH>=3: one instruction per cycle.
  - With DEPTH=2, at most one instruction every 2 cycles.
- With IF_READY=0, issue stalls once count + inflight_q reaches DEPTH. BUS.en stays 0 until a pop frees a slot; the cycle after that pop, issue resumes.

## Configuration
- DARKFETCH_ALIGN_CHECK_EN defined:
  - A redirect with REDIR_PC[1:0] != 0 sets fault_q and IF_FAULT=1.
  - Issue is then blocked; the FIFO is flushed as normal.
  - A later aligned redirect clears fault_q and fetching resumes.
- Not defined:
  - There is no IF_FAULT port and fault_q is constant 0.
  - REDIR_PC[1:0] is silently masked to 0.

## Structure
- Package darkfetch_pkg holds:
  - typedef fetch_entry_t, a packed struct {logic [31:0] pc; logic [31:0] data;}.
  - Constant NOP_INSN = 32'h0000_0013.
  - Constant FETCH_STRIDE = 4.
- Sub-module darkfetch_fifo: a synchronous FIFO of fetch_entry_t, parameterised by DEPTH, with push, pop, flush, count and head outputs. It uses the same asynchronous active-low reset.
- The top level holds pc_q, the in-flight tracking, the issue and credit logic, and the fault logic.

## Test plan
- Reset release with RESET_PC=0 and IF_READY=1, paired with a 1-cycle ROM model:
  - BUS.addr is 0, 4, 8, ... on consecutive cycles.
  - IF_PC is 0, 4, 8, ... from cycle 2, with IF_VALID continuous.
- IF_READY=0 from cycle 0 with DEPTH=4:
  - Exactly 4 issues occur (addr 0 to C), then BUS.en=0.
  - Raising IF_READY gives 4 pops, and issuing resumes at 0x10.
- Redirect to 0x100 while the FIFO holds 3 entries and a read is in flight:
  - IF_VALID=0 the next cycle.
  - BUS.addr=0x100 one cycle after REDIR.
  - IF_PC=0x100 three cycles after REDIR.
  - No stale entries appear.
- pc_q=0xFFFF_FFF8: BUS.addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted mid-stream with a read in flight: the late BUS.valid is ignored, IF_VALID=0, and the first issue after release is RESET_PC.
- With DARKFETCH_ALIGN_CHECK_EN:
  - REDIR_PC=0x102 gives IF_FAULT=1 and BUS.en=0 indefinitely.
  - A following REDIR_PC=0x200 clears IF_FAULT and fetches 0x200.
